imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 13 +
 rtl/imem_loader_if.sv | 28 ++
 rtl/imem_loader_stp_shifter.sv | 33 +++
 rtl/imem_loader.sv | 101 ++++++++++
 tb/tb_imem_loader.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader shared definitions: FSM state encoding and byte width.
// Imported by the interface, the shifter and the top level.
package imem_loader_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte write bus between the loader (master) and simpleBus (slave).
// Ports: d_valid, data_imem, addr_imem (master out), grant (slave out).
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int m = 32
);

    logic              d_valid;
    logic [BYTE_W-1:0] data_imem;
    logic [m-1:0]      addr_imem;
    logic              grant;

    modport master (
        output d_valid,
        output data_imem,
        output addr_imem,
        input  grant
    );

    modport slave (
        input  d_valid,
        input  data_imem,
        input  addr_imem,
        output grant
    );

endinterface

// File: rtl/imem_loader_stp_shifter.sv
// Serial-to-parallel shifter: MSB-first shift register and bit counter.
// Ports: clk, rst, clear, en, sin in; byte_out, byte_done out.
module stp_shifter
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic              sin,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_done
);

    logic [BYTE_W-1:0] shreg;
    logic [2:0]        bit_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (en) begin
            shreg   <= {shreg[BYTE_W-2:0], sin};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // Completion is flagged in the cycle the 8th bit arrives, with the
    // byte already including it, so the top registers it on that edge.
    assign byte_out  = {shreg[BYTE_W-2:0], sin};
    assign byte_done = en && !clear && (bit_cnt == 3'd7);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: deserializes sin into bytes and writes them
// to consecutive addresses over the bus; ports clk, rst, start, num_bytes,
// sin, sin_valid, bus (master), busy, load_done, overrun.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int           m         = 32,
    parameter logic [m-1:0] BASE_ADDR = '0,
    parameter int           CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_bytes,
    input  logic               sin,
    input  logic               sin_valid,
    imem_loader_if.master      bus,
    output logic               busy,
    output logic               load_done,
    output logic               overrun
);

    state_t            state;
    logic [CNT_W-1:0]  target;
    logic [CNT_W-1:0]  byte_cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              d_valid_q;
    logic [BYTE_W-1:0] data_q;
    logic [m-1:0]      addr_q;
    logic [BYTE_W-1:0] byte_out;
    logic              byte_done;
    logic              shift_en;
    logic              accept;
    logic              last;

    assign shift_en = sin_valid && (state == ST_LOAD);
    assign accept   = d_valid_q && bus.grant;
    assign cnt_next = byte_cnt + CNT_W'(1);
    assign last     = accept && (cnt_next == target);

    stp_shifter u_shifter (
        .clk      (clk),
        .rst      (rst),
        .clear    (start),
        .en       (shift_en),
        .sin      (sin),
        .byte_out (byte_out),
        .byte_done(byte_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            d_valid_q <= 1'b0;
            data_q    <= '0;
            addr_q    <= BASE_ADDR;
            busy      <= 1'b0;
            load_done <= 1'b0;
            overrun   <= 1'b0;
            target    <= '0;
            byte_cnt  <= '0;
        end else if (start) begin
            // A pending byte is discarded here and never accepted.
            state     <= (num_bytes == '0) ? ST_DONE : ST_LOAD;
            d_valid_q <= 1'b0;
            addr_q    <= BASE_ADDR;
            busy      <= (num_bytes != '0);
            load_done <= (num_bytes == '0);
            overrun   <= 1'b0;
            target    <= num_bytes;
            byte_cnt  <= '0;
        end else if (state == ST_LOAD) begin
            if (accept) begin
                addr_q   <= addr_q + m'(1);
                byte_cnt <= cnt_next;
            end
            if (last) begin
                // Any byte completing alongside the final accept is extra.
                state     <= ST_DONE;
                d_valid_q <= 1'b0;
                busy      <= 1'b0;
                load_done <= 1'b1;
            end else if (byte_done && (!d_valid_q || accept)) begin
                data_q    <= byte_out;
                d_valid_q <= 1'b1;
            end else begin
                if (byte_done) begin
                    overrun <= 1'b1;
                end
                if (accept) begin
                    d_valid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.d_valid   = d_valid_q;
    assign bus.data_imem = data_q;
    assign bus.addr_imem = addr_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes,
// a negedge monitor pops them on every accepted bus transfer.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_bytes;
    logic        sin;
    logic        sin_valid;
    logic        busy;
    logic        load_done;
    logic        overrun;
    logic        tie;
    logic        grant_man;

    imem_loader_if #(.m(32)) bus ();

    assign bus.grant = tie ? bus.d_valid : grant_man;

    imem_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .num_bytes(num_bytes),
        .sin      (sin),
        .sin_valid(sin_valid),
        .bus      (bus.master),
        .busy     (busy),
        .load_done(load_done),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [39:0] exp_q[$];

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    // Monitor: transfer is taken at the next posedge when valid & grant.
    logic        pv = 1'b0;
    logic        pa = 1'b0;
    logic [7:0]  pd = '0;
    logic [31:0] pad = '0;

    always @(negedge clk) begin
        logic [39:0] e;
        if (!rst) begin
            if (pv && !pa && bus.d_valid) begin
                check("hold_data", 64'(bus.data_imem), 64'(pd));
                check("hold_addr", 64'(bus.addr_imem), 64'(pad));
            end
            if (bus.d_valid && bus.grant) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_accept: addr %0h data %0h, none expected",
                             bus.addr_imem, bus.data_imem);
                end else begin
                    e = exp_q.pop_front();
                    check("acc_addr", 64'(bus.addr_imem), 64'(e[39:8]));
                    check("acc_data", 64'(bus.data_imem), 64'(e[7:0]));
                end
            end
        end
        pv  <= bus.d_valid && !rst;
        pa  <= bus.d_valid && bus.grant;
        pd  <= bus.data_imem;
        pad <= bus.addr_imem;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        for (int i = 7; i >= 0; i--) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(gap_max, 0)) begin
                    sin_valid = 1'b0;
                    sin = 1'($urandom);
                    tick();
                end
            end
            sin = b[i];
            sin_valid = 1'b1;
            tick();
        end
        sin_valid = 1'b0;
    endtask

    task automatic do_start(input int n);
        num_bytes = 16'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        num_bytes = 16'($urandom);
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!load_done && k < 200) begin
            tick();
            k++;
        end
        check(name, 64'(load_done), 64'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] word[4];
        logic [7:0] b;
        int n;

        rst = 1'b1;
        start = 1'b0;
        num_bytes = '0;
        sin = 1'b0;
        sin_valid = 1'b0;
        tie = 1'b1;
        grant_man = 1'b0;
        tick();
        rst = 1'b0;

        // Reset state, then bits in IDLE are ignored.
        for (int i = 0; i < 16; i++) begin
            sin = 1'($urandom);
            sin_valid = 1'(i & 1);
            tick();
        end
        sin_valid = 1'b0;
        check("idle_d_valid", 64'(bus.d_valid), 64'd0);
        check("idle_data", 64'(bus.data_imem), 64'd0);
        check("idle_addr", 64'(bus.addr_imem), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_done", 64'(load_done), 64'd0);
        check("idle_overrun", 64'(overrun), 64'd0);

        // Single 32-bit word, grant tied to d_valid.
        word[0] = 8'h13;
        word[1] = 8'h05;
        word[2] = 8'h10;
        word[3] = 8'h00;
        do_start(4);
        check("word_busy", 64'(busy), 64'd1);
        for (int j = 0; j < 4; j++) begin
            push(32'(j), word[j]);
            send_byte(word[j], 0);
            check("word_valid", 64'(bus.d_valid), 64'd1);
        end
        tick();
        check("word_done", 64'(load_done), 64'd1);
        check("word_busy_end", 64'(busy), 64'd0);
        check("word_addr_end", 64'(bus.addr_imem), 64'd4);
        check("word_valid_end", 64'(bus.d_valid), 64'd0);

        // Delayed grant: byte held stable until grant.
        tie = 1'b0;
        grant_man = 1'b0;
        do_start(2);
        push(32'd0, 8'hC3);
        send_byte(8'hC3, 0);
        for (int j = 0; j < 5; j++) begin
            check("dly_valid", 64'(bus.d_valid), 64'd1);
            check("dly_data", 64'(bus.data_imem), 64'hC3);
            check("dly_addr", 64'(bus.addr_imem), 64'd0);
            tick();
        end
        grant_man = 1'b1;
        tick();
        grant_man = 1'b0;
        check("dly_valid_fall", 64'(bus.d_valid), 64'd0);
        check("dly_addr_inc", 64'(bus.addr_imem), 64'd1);
        tie = 1'b1;
        push(32'd1, 8'h9E);
        send_byte(8'h9E, 0);
        wait_done("dly_done");
        check("dly_addr_end", 64'(bus.addr_imem), 64'd2);

        // Overrun: first byte kept, later completed bytes dropped.
        tie = 1'b0;
        grant_man = 1'b0;
        do_start(2);
        check("ovr_cleared", 64'(overrun), 64'd0);
        push(32'd0, 8'hA5);
        send_byte(8'hA5, 0);
        check("ovr_first", 64'(overrun), 64'd0);
        send_byte(8'h3C, 0);
        check("ovr_set", 64'(overrun), 64'd1);
        check("ovr_keep", 64'(bus.data_imem), 64'hA5);
        send_byte(8'h77, 0);
        check("ovr_keep2", 64'(bus.data_imem), 64'hA5);
        grant_man = 1'b1;
        tick();
        grant_man = 1'b0;
        tie = 1'b1;
        push(32'd1, 8'h5A);
        send_byte(8'h5A, 0);
        wait_done("ovr_done");
        check("ovr_sticky", 64'(overrun), 64'd1);

        // Restart mid-load, discarding a pending byte.
        do_start(4);
        check("rst_ovr_clr", 64'(overrun), 64'd0);
        push(32'd0, 8'h11);
        send_byte(8'h11, 0);
        push(32'd1, 8'h22);
        send_byte(8'h22, 0);
        tick();
        tick();
        tie = 1'b0;
        grant_man = 1'b0;
        send_byte(8'h33, 0);
        check("rs_pending", 64'(bus.d_valid), 64'd1);
        do_start(1);
        check("rs_valid", 64'(bus.d_valid), 64'd0);
        check("rs_addr", 64'(bus.addr_imem), 64'd0);
        check("rs_busy", 64'(busy), 64'd1);
        check("rs_done", 64'(load_done), 64'd0);
        tie = 1'b1;
        push(32'd0, 8'h44);
        send_byte(8'h44, 0);
        wait_done("rs_done_end");
        check("rs_addr_end", 64'(bus.addr_imem), 64'd1);

        // Zero length.
        do_start(0);
        check("z_done", 64'(load_done), 64'd1);
        check("z_busy", 64'(busy), 64'd0);
        send_byte(8'hFF, 1);
        send_byte(8'h01, 1);
        check("z_valid", 64'(bus.d_valid), 64'd0);
        check("z_done_hold", 64'(load_done), 64'd1);

        // Randomized loads with bit gaps and trailing noise bits.
        for (int l = 0; l < 6; l++) begin
            n = $urandom_range(6, 1);
            do_start(n);
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                push(32'(j), b);
                send_byte(b, 2);
            end
            wait_done("rnd_done");
            check("rnd_addr", 64'(bus.addr_imem), 64'(n));
            check("rnd_busy", 64'(busy), 64'd0);
            for (int k = 0; k < 12; k++) begin
                sin = 1'($urandom);
                sin_valid = 1'($urandom);
                tick();
            end
            sin_valid = 1'b0;
            check("rnd_done_hold", 64'(load_done), 64'd1);
        end

        tick();
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
